rc4_msg_checker: RTL and testbench

- Reader at the far end of the decrypted-message memory (d_memory).
- The decrypt FSM writes plaintext bytes; this block reads them back after decryption and reports whether the whole message is printable lowercase text.
- The key-search controller uses the done/valid result to accept the current key or advance to the next one.
- Sits beside the decrypt FSM and time-shares d_memory; it never writes.

---
 rtl/rc4_msg_checker.sv | 136 +++++++++++++
 tb/tb_rc4_msg_checker.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rc4_msg_checker.sv
// Reads the decrypted message back from d_memory and reports whether every byte is a space or 'a'..'z'.
// Optional first_bad output is enabled with `define RC4_MSG_CHECKER_FIRST_BAD_EN.
module rc4_msg_checker #(
    parameter int MSG_LEN = 32,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    output logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] q,
    output logic              busy,
    output logic              done,
    output logic              valid
`ifdef RC4_MSG_CHECKER_FIRST_BAD_EN
    ,
    output logic [ADDR_W-1:0] first_bad
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_CHECK,
        S_DONE
    } state_t;

    // The last-byte compare happens before any increment, so an ADDR_W-bit index never overflows.
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(MSG_LEN - 1);

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_index, w_index_nxt;
    logic [ADDR_W-1:0] r_address, w_address_nxt;
    logic              r_busy, w_busy_nxt;
    logic              r_done, w_done_nxt;
    logic              r_valid, w_valid_nxt;
    logic              w_legal;
    logic              w_accept;

    function automatic logic byte_legal(input logic [DATA_W-1:0] b);
        logic [7:0] lo;
        lo = b[7:0];
        if ((b >> 8) != '0) return 1'b0;
        return (lo == 8'h20) || ((lo >= 8'h61) && (lo <= 8'h7A));
    endfunction

    assign w_legal  = byte_legal(q);
    assign w_accept = (r_state == S_IDLE) && start;

    always_comb begin
        w_state_nxt   = r_state;
        w_index_nxt   = r_index;
        w_address_nxt = r_address;
        w_busy_nxt    = r_busy;
        w_done_nxt    = r_done;
        w_valid_nxt   = r_valid;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_index_nxt   = '0;
                    w_address_nxt = '0;
                    w_busy_nxt    = 1'b1;
                    w_valid_nxt   = 1'b0;
                    w_state_nxt   = S_READ;
                end
            end
            S_READ: w_state_nxt = S_CHECK;
            S_CHECK: begin
                if (!w_legal) begin
                    w_valid_nxt = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = S_DONE;
                end else if (r_index == LAST_IDX) begin
                    w_valid_nxt = 1'b1;
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = S_DONE;
                end else begin
                    w_index_nxt   = r_index + 1'b1;
                    w_address_nxt = r_index + 1'b1;
                    w_state_nxt   = S_READ;
                end
            end
            S_DONE: begin
                // Requiring start low here is what stops a held start from retriggering.
                if (!start) begin
                    w_done_nxt  = 1'b0;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_index   <= '0;
            r_address <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_valid   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_index   <= w_index_nxt;
            r_address <= w_address_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_valid   <= w_valid_nxt;
        end
    end

    assign address = r_address;
    assign busy    = r_busy;
    assign done    = r_done;
    assign valid   = r_valid;

`ifdef RC4_MSG_CHECKER_FIRST_BAD_EN
    logic [ADDR_W-1:0] r_first_bad;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_first_bad <= '0;
        end else if (w_accept) begin
            r_first_bad <= '0;
        end else if (r_state == S_CHECK) begin
            r_first_bad <= w_legal ? '0 : r_index;
        end
    end

    assign first_bad = r_first_bad;
`endif

endmodule

// File: tb/tb_rc4_msg_checker.sv
// Scoreboard bench for rc4_msg_checker: randomized and corner-case messages against a behavioural model.
module tb_rc4_msg_checker;

    localparam int MSGLEN = 32;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic [7:0] address;
    logic [7:0] q;
    logic       busy, done, valid;
    logic       start1;
    logic [7:0] address1;
    logic [7:0] q1;
    logic       busy1, done1, valid1;
`ifdef RC4_MSG_CHECKER_FIRST_BAD_EN
    logic [7:0] first_bad;
    logic [7:0] first_bad1;
`endif

    logic [7:0] mem [0:255];
    logic [7:0] m1;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic        v;
        logic [15:0] lat;
        logic [7:0]  last;
        logic [7:0]  fb;
    } exp_t;

    exp_t exp_q[$];

    rc4_msg_checker #(.MSG_LEN(MSGLEN), .ADDR_W(8), .DATA_W(8)) u_dut (
        .clk(clk), .reset_n(reset_n), .start(start), .address(address), .q(q),
        .busy(busy), .done(done), .valid(valid)
`ifdef RC4_MSG_CHECKER_FIRST_BAD_EN
        , .first_bad(first_bad)
`endif
    );

    rc4_msg_checker #(.MSG_LEN(1), .ADDR_W(8), .DATA_W(8)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .start(start1), .address(address1), .q(q1),
        .busy(busy1), .done(done1), .valid(valid1)
`ifdef RC4_MSG_CHECKER_FIRST_BAD_EN
        , .first_bad(first_bad1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) q  <= mem[address];
    always @(posedge clk) q1 <= m1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic is_text(input logic [7:0] b);
        return b inside {8'h20, [8'h61:8'h7A]};
    endfunction

    function automatic exp_t model();
        exp_t e;
        e.v    = 1'b1;
        e.lat  = 16'(2 * MSGLEN);
        e.last = 8'(MSGLEN - 1);
        e.fb   = 8'h00;
        for (int i = 0; i < MSGLEN; i++) begin
            if (!is_text(mem[i])) begin
                e.v    = 1'b0;
                e.lat  = 16'(2 * (i + 1));
                e.last = 8'(i);
                e.fb   = 8'(i);
                return e;
            end
        end
        return e;
    endfunction

    // Monitor: measures busy length and address sequence, pops the scoreboard when done rises.
    int   mon_cnt = 0;
    logic prev_busy = 1'b0;
    logic prev_done = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (busy === 1'b1) begin
            if (!prev_busy) mon_cnt = 1;
            else            mon_cnt++;
            check("addr_step", 32'(address), 32'((mon_cnt - 1) / 2));
        end
        if (done === 1'b1 && !prev_done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                check("latency", 32'(mon_cnt), 32'(e.lat));
                check("valid", 32'(valid), 32'(e.v));
                check("last_addr", 32'(address), 32'(e.last));
`ifdef RC4_MSG_CHECKER_FIRST_BAD_EN
                check("first_bad", 32'(first_bad), 32'(e.fb));
`endif
            end
        end
        prev_busy = busy;
        prev_done = done;
    end

    task automatic run_msg(input bit hold, input bit pulse);
        exp_t e;
        int   n;
        logic [7:0] saved;
        e = model();
        exp_q.push_back(e);
        start = 1'b1;
        tick();
        n = 0;
        while (done !== 1'b1 && n < 200) begin
            start = hold || (pulse && n == 6);
            tick();
            n++;
        end
        if (n >= 200) check("done_timeout", 32'(n), 32'(e.lat));
        if (hold) begin
            saved = address;
            for (int i = 0; i < 4; i++) begin
                tick();
                check("hold_done", 32'(done), 32'd1);
                check("hold_busy", 32'(busy), 32'd0);
                check("hold_addr", 32'(address), 32'(saved));
            end
            start = 1'b0;
        end
        tick();
        check("done_fall", 32'(done), 32'd0);
        check("valid_kept", 32'(valid), 32'(e.v));
        tick();
    endtask

    task automatic fill(input logic [7:0] b);
        for (int i = 0; i < 256; i++) mem[i] = (i < MSGLEN) ? b : 8'h00;
    endtask

    initial begin
        logic [7:0] bnd [3];
        logic [7:0] bad [4];
        int n;
        bnd[0] = 8'h20; bnd[1] = 8'h61; bnd[2] = 8'h7A;
        bad[0] = 8'h1F; bad[1] = 8'h21; bad[2] = 8'h60; bad[3] = 8'h7B;
        reset_n = 1'b0;
        start   = 1'b0;
        start1  = 1'b0;
        m1      = 8'h20;
        fill(8'h61);
        tick();
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_addr", 32'(address), 32'd0);
        reset_n = 1'b1;
        tick();

        fill(8'h61);
        run_msg(1'b0, 1'b0);

        mem[5] = 8'h7B;
        run_msg(1'b0, 1'b0);

        for (int i = 0; i < MSGLEN; i++) mem[i] = bnd[i % 3];
        run_msg(1'b1, 1'b0);

        for (int k = 0; k < 4; k++) begin
            fill(8'h61);
            mem[MSGLEN-1] = bad[k];
            run_msg(1'b0, 1'b0);
        end

        fill(8'h7A);
        run_msg(1'b0, 1'b1);

        // Abort an all-legal check with a one-clock reset on edge 20.
        fill(8'h61);
        exp_q.push_back(model());
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 19; i++) tick();
        reset_n = 1'b0;
        tick();
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_valid", 32'(valid), 32'd0);
        check("abort_addr", 32'(address), 32'd0);
`ifdef RC4_MSG_CHECKER_FIRST_BAD_EN
        check("abort_first_bad", 32'(first_bad), 32'd0);
`endif
        reset_n = 1'b1;
        void'(exp_q.pop_back());
        tick();
        run_msg(1'b0, 1'b0);

        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < MSGLEN; i++) begin
                n = int'($urandom_range(0, 26));
                mem[i] = (n == 26) ? 8'h20 : 8'(8'h61 + n);
            end
            if ($urandom_range(0, 3) != 0)
                mem[$urandom_range(0, MSGLEN-1)] = 8'($urandom_range(0, 255));
            run_msg(1'(r % 5 == 0), 1'b0);
        end

        // Single-byte build: legal then illegal.
        for (int t = 0; t < 2; t++) begin
            m1 = (t == 0) ? 8'h20 : 8'h7B;
            start1 = 1'b1;
            tick();
            start1 = 1'b0;
            n = 0;
            while (done1 !== 1'b1 && n < 20) begin
                tick();
                n++;
            end
            check("len1_latency", 32'(n), 32'd2);
            check("len1_valid", 32'(valid1), 32'(t == 0));
            check("len1_addr", 32'(address1), 32'd0);
`ifdef RC4_MSG_CHECKER_FIRST_BAD_EN
            check("len1_first_bad", 32'(first_bad1), 32'd0);
`endif
            tick();
            tick();
        end

        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
